wb_arbiter: RTL and testbench

//  Writeback arbiter feeding the single write port (ard/drd) of the physical register file.

---
 rtl/wb_arbiter_if.sv | 35 +++
 rtl/wb_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: per-source valid/ready result handshakes plus the
// single register-file write port driven by the arbiter.
`ifndef LEN_PREG_ADDR
`define LEN_PREG_ADDR 7
`endif
`ifndef LEN_WORD
`define LEN_WORD 32
`endif

interface wb_arbiter_if #(
  parameter int NUM_SRC = 3,
  parameter int AW      = `LEN_PREG_ADDR,
  parameter int DW      = `LEN_WORD
);
  logic [NUM_SRC-1:0]    i_valid;
  logic [NUM_SRC-1:0]    o_ready;
  logic [NUM_SRC*AW-1:0] i_addr;
  logic [NUM_SRC*DW-1:0] i_data;
  logic [AW-1:0]         o_ard;
  logic [DW-1:0]         o_drd;
  logic                  o_wb;
  logic [NUM_SRC-1:0]    o_grant;

  // Execution-unit side: presents results, sees the register write port.
  modport master (
    output i_valid, i_addr, i_data,
    input  o_ready, o_ard, o_drd, o_wb, o_grant
  );

  // Arbiter side.
  modport slave (
    input  i_valid, i_addr, i_data,
    output o_ready, o_ard, o_drd, o_wb, o_grant
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers results from NUM_SRC units in per-source FIFOs and
// issues at most one register-file write per cycle in round-robin order.
`ifndef LEN_PREG_ADDR
`define LEN_PREG_ADDR 7
`endif
`ifndef LEN_WORD
`define LEN_WORD 32
`endif

module wb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 2,
  parameter int AW      = `LEN_PREG_ADDR,
  parameter int DW      = `LEN_WORD
) (
  input logic         clk,
  input logic         rstn,
  wb_arbiter_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [AW-1:0]      addr_mem_q [NUM_SRC][DEPTH];
  logic [DW-1:0]      data_mem_q [NUM_SRC][DEPTH];
  logic [PW-1:0]      rd_ptr_q   [NUM_SRC];
  logic [PW-1:0]      wr_ptr_q   [NUM_SRC];
  logic [CW-1:0]      count_q    [NUM_SRC];
  logic [SW-1:0]      rr_ptr_q;
  logic [SW-1:0]      rr_ptr_d;

  logic [NUM_SRC-1:0] ready_s;
  logic [NUM_SRC-1:0] push_s;
  logic [NUM_SRC-1:0] pop_s;
  logic [NUM_SRC-1:0] nonempty_s;
  logic               win_s;
  logic [SW-1:0]      win_idx_s;

  logic [AW-1:0]      ard_q,   ard_d;
  logic [DW-1:0]      drd_q,   drd_d;
  logic               wb_q,    wb_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;

  // Per-source handshake: ready from registered occupancy only; addr 0 completes but is dropped.
  always_comb begin
    ready_s    = {NUM_SRC{1'b0}};
    push_s     = {NUM_SRC{1'b0}};
    nonempty_s = {NUM_SRC{1'b0}};
    for (int s = 0; s < NUM_SRC; s++) begin
      ready_s[s]    = rstn && (count_q[s] < CW'(DEPTH));
      nonempty_s[s] = (count_q[s] != {CW{1'b0}});
      push_s[s]     = bus.i_valid[s] && ready_s[s] &&
                      (bus.i_addr[s*AW +: AW] != {AW{1'b0}});
    end
  end

  // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_SRC.
  always_comb begin
    int cand;
    cand      = 0;
    win_s     = 1'b0;
    win_idx_s = {SW{1'b0}};
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_SRC) begin
        cand = cand - NUM_SRC;
      end else begin
        cand = cand;
      end
      if (!win_s && nonempty_s[SW'(cand)]) begin
        win_s     = 1'b1;
        win_idx_s = SW'(cand);
      end else begin
        win_s     = win_s;
      end
    end
  end

  // Pop the winner's head, advance the pointer past it, and build the next write.
  always_comb begin
    pop_s    = {NUM_SRC{1'b0}};
    rr_ptr_d = rr_ptr_q;
    ard_d    = {AW{1'b0}};
    drd_d    = {DW{1'b0}};
    wb_d     = 1'b0;
    grant_d  = {NUM_SRC{1'b0}};
    if (win_s) begin
      pop_s[win_idx_s]   = 1'b1;
      grant_d[win_idx_s] = 1'b1;
      ard_d              = addr_mem_q[win_idx_s][rd_ptr_q[win_idx_s]];
      drd_d              = data_mem_q[win_idx_s][rd_ptr_q[win_idx_s]];
      wb_d               = 1'b1;
      if (win_idx_s == SW'(NUM_SRC - 1)) begin
        rr_ptr_d = {SW{1'b0}};
      end else begin
        rr_ptr_d = win_idx_s + SW'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // FIFO storage; writes are gated by push_s, which is already low during reset.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (push_s[s]) begin
        addr_mem_q[s][wr_ptr_q[s]] <= bus.i_addr[s*AW +: AW];
        data_mem_q[s][wr_ptr_q[s]] <= bus.i_data[s*DW +: DW];
      end
    end
  end

  // FIFO pointers/occupancy, round-robin pointer and the registered write port.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        rd_ptr_q[s] <= {PW{1'b0}};
        wr_ptr_q[s] <= {PW{1'b0}};
        count_q[s]  <= {CW{1'b0}};
      end
      rr_ptr_q <= {SW{1'b0}};
      ard_q    <= {AW{1'b0}};
      drd_q    <= {DW{1'b0}};
      wb_q     <= 1'b0;
      grant_q  <= {NUM_SRC{1'b0}};
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (push_s[s]) begin
          wr_ptr_q[s] <= wr_ptr_q[s] + PW'(1);
        end
        if (pop_s[s]) begin
          rd_ptr_q[s] <= rd_ptr_q[s] + PW'(1);
        end
        case ({push_s[s], pop_s[s]})
          2'b10:   count_q[s] <= count_q[s] + CW'(1);
          2'b01:   count_q[s] <= count_q[s] - CW'(1);
          default: count_q[s] <= count_q[s];
        endcase
      end
      rr_ptr_q <= rr_ptr_d;
      ard_q    <= ard_d;
      drd_q    <= drd_d;
      wb_q     <= wb_d;
      grant_q  <= grant_d;
    end
  end

  assign bus.o_ready = ready_s;
  assign bus.o_ard   = ard_q;
  assign bus.o_drd   = drd_q;
  assign bus.o_wb    = wb_q;
  assign bus.o_grant = grant_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a queue-based model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_wb_arbiter;
  localparam int N     = 3;
  localparam int DEPTH = 2;
  localparam int AW    = 7;
  localparam int DW    = 32;

  logic clk;
  logic rstn;
  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 1'b0;

  wb_arbiter_if #(.NUM_SRC(N), .AW(AW), .DW(DW)) bus ();

  wb_arbiter #(.NUM_SRC(N), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per-source queues of {addr,data}, a round-robin index, expected registered outputs.
  logic [AW+DW-1:0] mq   [N][$];
  logic [AW+DW-1:0] pend [N][$];
  int               mptr = 0;
  logic [AW-1:0]    exp_ard   = '0;
  logic [DW-1:0]    exp_drd   = '0;
  logic             exp_wb    = 1'b0;
  logic [N-1:0]     exp_grant = '0;

  logic [AW-1:0]    log_addr  [$];
  logic [N-1:0]     log_grant [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW+DW-1:0] mk(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {a, d};
  endfunction

  task automatic model_step();
    logic [N-1:0]     rdy;
    logic [AW+DW-1:0] e;
    int               w;
    int               c;
    if (!rstn) begin
      for (int s = 0; s < N; s++) mq[s].delete();
      mptr = 0;
      exp_ard = '0; exp_drd = '0; exp_wb = 1'b0; exp_grant = '0;
    end else begin
      for (int s = 0; s < N; s++) rdy[s] = (mq[s].size() < DEPTH);
      w = -1;
      for (int k = 0; k < N; k++) begin
        c = (mptr + k) % N;
        if (w < 0 && mq[c].size() > 0) w = c;
      end
      exp_grant = '0;
      if (w >= 0) begin
        e = mq[w].pop_front();
        exp_ard      = e[AW+DW-1:DW];
        exp_drd      = e[DW-1:0];
        exp_wb       = 1'b1;
        exp_grant[w] = 1'b1;
        mptr         = (w + 1) % N;
      end else begin
        exp_ard = '0; exp_drd = '0; exp_wb = 1'b0;
      end
      for (int s = 0; s < N; s++)
        if (bus.i_valid[s] && rdy[s] && bus.i_addr[s*AW +: AW] != '0)
          mq[s].push_back({bus.i_addr[s*AW +: AW], bus.i_data[s*DW +: DW]});
    end
  endtask

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      if (pend[s].size() > 0) begin
        bus.i_valid[s]          = 1'b1;
        bus.i_addr[s*AW +: AW]  = pend[s][0][AW+DW-1:DW];
        bus.i_data[s*DW +: DW]  = pend[s][0][DW-1:0];
      end else begin
        bus.i_valid[s] = 1'b0;
      end
    end
  endtask

  // One clock: drive heads, sample ready before the edge, update model at the edge.
  task automatic tick();
    logic [N-1:0] rdy;
    logic [N-1:0] vld;
    drive();
    @(negedge clk);
    rdy = bus.o_ready;
    vld = bus.i_valid;
    @(posedge clk);
    model_step();
    for (int s = 0; s < N; s++)
      if (vld[s] && rdy[s]) void'(pend[s].pop_front());
    #2;
    if (bus.o_wb) begin
      log_addr.push_back(bus.o_ard);
      log_grant.push_back(bus.o_grant);
    end
  endtask

  task automatic clear_pend();
    for (int s = 0; s < N; s++) pend[s].delete();
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    if (chk_en) begin
      for (int s = 0; s < N; s++) exp_rdy[s] = rstn && (mq[s].size() < DEPTH);
      chk("model_ready", 64'(bus.o_ready), 64'(exp_rdy));
      chk("model_ard",   64'(bus.o_ard),   64'(exp_ard));
      chk("model_drd",   64'(bus.o_drd),   64'(exp_drd));
      chk("model_wb",    64'(bus.o_wb),    64'(exp_wb));
      chk("model_grant", 64'(bus.o_grant), 64'(exp_grant));
    end
  end

  initial begin
    int n2;
    logic [AW-1:0] exp2 [4];
    bus.i_valid = '0;
    bus.i_addr  = '0;
    bus.i_data  = '0;
    rstn = 1'b0;

    // 1: reset holds ready low even with valid asserted
    tick();
    chk_en = 1'b1;
    for (int s = 0; s < N; s++) pend[s].push_back(mk(AW'(s + 1), DW'(s)));
    tick();
    tick();
    chk("rst_ready", 64'(bus.o_ready), 64'(3'b000));
    chk("rst_ard",   64'(bus.o_ard),   64'd0);
    chk("rst_wb",    64'(bus.o_wb),    64'd0);
    clear_pend();
    drive();
    rstn = 1'b1;
    #1;
    chk("rel_ready", 64'(bus.o_ready), 64'(3'b111));

    // 2: single result from src1
    pend[1].push_back(mk(7'd5, 32'hDEADBEEF));
    tick();
    chk("single_e0_wb", 64'(bus.o_wb), 64'd0);
    tick();
    chk("single_ard",   64'(bus.o_ard),   64'd5);
    chk("single_drd",   64'(bus.o_drd),   64'hDEADBEEF);
    chk("single_grant", 64'(bus.o_grant), 64'(3'b010));
    tick();
    chk("single_e2_ard", 64'(bus.o_ard), 64'd0);

    // 3: round robin from a freshly reset pointer
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    pend[0].push_back(mk(7'd4,  32'h4));
    pend[1].push_back(mk(7'd8,  32'h8));
    pend[2].push_back(mk(7'd12, 32'hC));
    tick();
    chk("rr_e0_wb", 64'(bus.o_wb), 64'd0);
    tick(); chk("rr_w1", 64'(bus.o_ard), 64'd4);
    tick(); chk("rr_w2", 64'(bus.o_ard), 64'd8);
    tick(); chk("rr_w3", 64'(bus.o_ard), 64'd12);
    pend[0].push_back(mk(7'd20, 32'h14));
    pend[1].push_back(mk(7'd24, 32'h18));
    tick();
    tick(); chk("rr_w4", 64'(bus.o_ard), 64'd20);
    tick(); chk("rr_w5", 64'(bus.o_ard), 64'd24);
    tick(); chk("rr_idle", 64'(bus.o_wb), 64'd0);

    // 4: src2 backpressure while src0 stays busy
    log_addr.delete();
    log_grant.delete();
    for (int i = 0; i < 4; i++) begin
      pend[0].push_back(mk(AW'(30 + i), DW'(32'h300 + i)));
      pend[2].push_back(mk(AW'(40 + i), DW'(32'h400 + i)));
    end
    n2 = 0;
    for (int t = 0; t < 14; t++) begin
      tick();
      if (bus.o_ready[2] == 1'b0) n2++;
    end
    chk("bp_ready2_low_seen", 64'(n2 > 0), 64'd1);
    chk("bp_total_writes", 64'(log_addr.size()), 64'd8);
    exp2 = '{7'd40, 7'd41, 7'd42, 7'd43};
    n2 = 0;
    for (int i = 0; i < log_addr.size(); i++) begin
      if (log_grant[i] == 3'b100) begin
        if (n2 < 4) chk("bp_src2_order", 64'(log_addr[i]), 64'(exp2[n2]));
        n2++;
      end
    end
    chk("bp_src2_count", 64'(n2), 64'd4);

    // 5: address 0 handshakes but never writes
    log_addr.delete();
    log_grant.delete();
    pend[0].push_back(mk(7'd0, 32'd7));
    tick();
    chk("a0_accepted", 64'(pend[0].size()), 64'd0);
    for (int t = 0; t < 4; t++) tick();
    chk("a0_no_write", 64'(log_addr.size()), 64'd0);

    // 6: reset while FIFOs are loaded
    for (int s = 0; s < N; s++)
      for (int i = 0; i < 2; i++) pend[s].push_back(mk(AW'(50 + 2*s + i), DW'(s)));
    tick();
    tick();
    clear_pend();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    drive();
    #1;
    chk("mid_rst_ready", 64'(bus.o_ready), 64'(3'b111));
    log_addr.delete();
    log_grant.delete();
    for (int t = 0; t < 5; t++) tick();
    chk("mid_rst_no_write", 64'(log_addr.size()), 64'd0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
